// File: rtl/booth_arb_pkg.sv
// Shared types and helpers for the Booth multiplier arbiter: FSM state encoding
// and the round-robin grant search.
package booth_arb_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_ID_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  // First valid index at or after ptr, wrapping at n-1 -> 0; 0 if none valid.
  function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                  input logic [MAX_ID_W-1:0] ptr,
                                                  input int unsigned         n);
    logic [MAX_ID_W-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && valid[idx]) begin
        pick  = MAX_ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier core: one iteration per step pulse.
// Holds a WIDTH+1 accumulator so that the most negative multiplicand cannot overflow.
module booth_seq_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] q,
  output logic             done
);

  localparam int unsigned ACC_W = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] m_q, m_d;
  logic [ACC_W-1:0] sum;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Add/subtract by the Booth pair, then arithmetic right shift of {acc,Q,q_m1}.
  always_comb begin
    acc_d = acc_q;
    m_d   = m_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    case ({q_q[0], qm1_q})
      2'b10:   sum = acc_q - m_q;
      2'b01:   sum = acc_q + m_q;
      default: sum = acc_q;
    endcase
    if (load) begin
      acc_d = '0;
      m_d   = {m_in[WIDTH-1], m_in};
      q_d   = q_in;
      qm1_d = 1'b0;
      cnt_d = '0;
    end else if (step) begin
      acc_d = {sum[ACC_W-1], sum[ACC_W-1:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc  = acc_q[WIDTH-1:0];
  assign q    = q_q;
  // High while the final iteration is being executed.
  assign done = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NUM_REQ clients.
// Optional macro BOOTH_ARB_ZERO_BYPASS_EN: zero operands skip the core and respond next cycle.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     busy
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rsp_valid_q, busy_q;

  logic [ID_W-1:0]  grant;
  logic [WIDTH-1:0] sel_mpl, sel_mcd;
  logic [WIDTH-1:0] core_q_in;
  logic             core_load, core_step, core_done;
  logic [WIDTH-1:0] core_acc, core_q;

  assign grant   = ID_W'(rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr_q), NUM_REQ));
  assign sel_mpl = req_multiplier[32'(grant) * WIDTH +: WIDTH];
  assign sel_mcd = req_multiplicand[32'(grant) * WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    req_ready = '0;
    core_load = 1'b0;
    core_step = 1'b0;
    core_q_in = sel_mpl;
    case (state_q)
      IDLE: begin
        if (!rst && |req_valid) begin
          req_ready[grant] = 1'b1;
          core_load        = 1'b1;
          id_d             = grant;
          state_d          = RUN;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
          // Loading Q=0 with acc=0 makes the core already hold a zero product.
          if (sel_mpl == '0 || sel_mcd == '0) begin
            core_q_in = '0;
            state_d   = RESP;
          end
`endif
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (core_done) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
    end
  end

  booth_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .step (core_step),
    .m_in (sel_mcd),
    .q_in (core_q_in),
    .acc  (core_acc),
    .q    (core_q),
    .done (core_done)
  );

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = {core_acc, core_q};
  assign busy       = busy_q;

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one sequential radix-2 Booth multiplier core among NUM_REQ requesters.
- Round-robin arbitration picks one request, latches its operands, runs the core for WIDTH iterations, then returns a tagged signed product over a valid/ready response channel.
- Sits between several datapath clients and the single multiplier resource. Only one multiply is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
WIDTH, 4, operand width in bits (signed two's complement, 4..16).
ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept strobe (one-hot or zero).
req_multiplier  input  NUM_REQ*WIDTH  packed operands; slice i belongs to requester i.
req_multiplicand  input  NUM_REQ*WIDTH  packed operands; slice i belongs to requester i.
rsp_valid  output  1  product available.
rsp_ready  input  1  consumer accepts product.
rsp_id  output  ID_W  index of the requester owning the product.
rsp_result  output  2*WIDTH  signed product.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high) is allowed at any time, including mid-multiply or mid-response. Values while rst is high:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - Core registers cleared; any in-flight operation is discarded, with no response.
- States: IDLE, RUN, RESP.
- IDLE:
  - req_ready is combinational, asserted only in IDLE.
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[grant]=1 in that cycle. A transfer happens when valid&&ready at the clock edge.
  - On transfer: latch operands and grant id, load core (acc=0, q_m1=0, Q=multiplier, count=0), go to RUN.
  - No req_valid: stay in IDLE.
- RUN, one Booth iteration per cycle:
  - {Q[0],q_m1}=10: acc-=M. 01: acc+=M. 00/11: no add.
  - Then arithmetic right shift of {acc,Q,q_m1}.
  - acc is WIDTH+1 bits so that M = -2^(WIDTH-1) never overflows.
  - After WIDTH iterations go to RESP.
- RESP:
  - rsp_valid=1; rsp_result={acc[WIDTH-1:0],Q}; rsp_id=latched id.
  - All three outputs stay stable until rsp_ready=1.
  - On handshake: rr_ptr=(id+1) mod NUM_REQ, go to IDLE.
  - rsp_valid falls on the next cycle. No back-to-back accept in the handshake cycle.
- Latency: rsp_valid is first high WIDTH+1 cycles after the accepting edge. Throughput is one product per WIDTH+2 cycles minimum.
- req_ready is 0 in RUN and RESP. req_valid may change freely there; it is ignored.
- A requester dropping req_valid before being granted is legal. It loses its slot, with no side effect.
- Full range correct: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits in 2*WIDTH signed bits.

Optional Feature:
BOOTH_ARB_ZERO_BYPASS_EN
- Defined: at accept, if either operand is 0, skip RUN and go directly to RESP with rsp_result=0. rsp_valid is high on the cycle after the accept edge (latency 1).
- Undefined: zero operands take the full WIDTH+1 latency like any other operands. The result is still 0.

Decomposition:
- Package booth_arb_pkg:
  - state enum (IDLE, RUN, RESP).
  - localparam for the state width.
  - function rr_pick(valid, ptr) returning the grant index.
- One natural sub-module, booth_seq_core:
  - Ports: load, M, Q, step, acc/Q outputs, done.
  - Holds the WIDTH+1 acc, Q, q_m1 and count.
- booth_mult_arbiter holds the FSM, rr_ptr, the id register and the response handshake.

Test Plan (NUM_REQ=4, WIDTH=4, rsp_ready=1 unless noted):
1. Single request, req 2: multiplier=3, multiplicand=-2 -> rsp_id=2, rsp_result=8'hFA (-6), rsp_valid exactly 5 cycles after accept.
2. Corner operands:
   - -8 x -8 -> 8'h40 (64).
   - -8 x 7 -> 8'hC8 (-56).
   - 7 x 7 -> 8'h31 (49).
3. Round robin: all req_valid=4'b1111 held continuously from reset -> grant and rsp_id order 0,1,2,3,0. Drop req 1 after its first grant -> order 0,2,3,0.
4. Backpressure: rsp_ready=0 for 6 cycles during RESP -> rsp_valid, rsp_id and rsp_result held constant. req_ready stays 0 throughout. Accept occurs only after the handshake.
5. Reset mid-RUN: assert rst two cycles after accept -> all outputs 0 immediately (asynchronous). No response is emitted. Next grant starts from requester 0.
6. Zero operand, 0 x -5:
   - Macro defined -> rsp_valid 1 cycle after accept, result 0.
   - Macro undefined -> result 0 after 5 cycles.
